// File: rtl/fft_pkg.sv
// Shared constants and FSM encoding for the fft2D tile scheduler.
// Tiles are 8x8 real samples fed as 8 row beats; results return as 4 double-row beats.
package fft_pkg;
    localparam int DATALEN        = 16;
    localparam int FFTCHNL        = 8;
    localparam int CMPLXLEN       = 2 * DATALEN;
    localparam int ROWS_PER_TILE  = 8;
    localparam int BEATS_PER_TILE = 4;
    localparam int TILEW          = 16;
    localparam int INW            = FFTCHNL * DATALEN;
    localparam int FFTINW         = FFTCHNL * CMPLXLEN;
    localparam int OUTW           = FFTCHNL * 4 * DATALEN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GAPW,
        S_WAITC,
        S_DRAIN
    } state_e;
endpackage

// File: rtl/fft2d_tile_sched_if.sv
// Job control, input-buffer read, fft2D and result-buffer signals of the tile scheduler.
interface fft2d_tile_sched_if #(
    parameter int ADDRW = 12
);
    logic                       start;
    logic [fft_pkg::TILEW-1:0]  num_tiles;
    logic [ADDRW-1:0]           src_base;
    logic [ADDRW-1:0]           dst_base;
    logic                       busy;
    logic                       done;
    logic                       err;
    logic                       rd_en;
    logic [ADDRW-1:0]           rd_addr;
    logic [fft_pkg::INW-1:0]    rd_data;
    logic                       fft_invalid;
    logic [fft_pkg::FFTINW-1:0] fft_indata;
    logic                       fft_outvalid;
    logic [fft_pkg::OUTW-1:0]   fft_outdata;
    logic                       wr_en;
    logic [ADDRW-1:0]           wr_addr;
    logic [fft_pkg::OUTW-1:0]   wr_data;

    modport slave (
        input  start, num_tiles, src_base, dst_base, rd_data, fft_outvalid, fft_outdata,
        output busy, done, err, rd_en, rd_addr, fft_invalid, fft_indata, wr_en, wr_addr, wr_data
    );

    modport master (
        output start, num_tiles, src_base, dst_base, rd_data, fft_outvalid, fft_outdata,
        input  busy, done, err, rd_en, rd_addr, fft_invalid, fft_indata, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/fft2d_out_collector.sv
// Captures fft2D output beats into the result buffer and retires a tile on its last beat.
// Beats with nothing in flight, or beyond the job's tile count, are dropped and flag err.
module fft2d_out_collector
    import fft_pkg::*;
#(
    parameter int ADDRW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [TILEW-1:0]  num_tiles,
    input  logic [ADDRW-1:0]  dst_base,
    input  logic              inflight_zero,
    input  logic              outvalid,
    input  logic [OUTW-1:0]   outdata,
    output logic              wr_en,
    output logic [ADDRW-1:0]  wr_addr,
    output logic [OUTW-1:0]   wr_data,
    output logic              retire,
    output logic              err
);
    logic [1:0]       beat_q;
    logic [TILEW-1:0] tout_q;
    logic             wr_en_q, err_q;
    logic [ADDRW-1:0] wr_addr_q;
    logic [OUTW-1:0]  wr_data_q;
    logic             take;

    assign take   = outvalid && !inflight_zero && (tout_q < num_tiles);
    assign retire = take && (beat_q == 2'(BEATS_PER_TILE - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q    <= '0;
            tout_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= take;
            if (clr) begin
                beat_q <= '0;
                tout_q <= '0;
            end else if (take) begin
                wr_addr_q <= dst_base + ADDRW'({tout_q, 2'b00}) + ADDRW'(beat_q);
                wr_data_q <= outdata;
                beat_q    <= beat_q + 2'd1;
                if (retire) tout_q <= tout_q + TILEW'(1);
            end
            if (outvalid && !take) err_q <= 1'b1;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign err     = err_q;
endmodule

// File: rtl/fft2d_tile_sched.sv
// Streams 8x8 tiles from the row buffer into fft2D, bounding tiles in flight since
// fft2D cannot stall; the collector writes results back and retires tiles.
module fft2d_tile_sched
    import fft_pkg::*;
#(
    parameter int ADDRW        = 12,
    parameter int MAX_INFLIGHT = 2,
    parameter int GAP          = 1
) (
    input  logic               clk,
    input  logic               rst,
    fft2d_tile_sched_if.slave  bus
);
    localparam logic [1:0] MAXI     = 2'(MAX_INFLIGHT);
    localparam logic [2:0] GAP_LAST = 3'(GAP > 0 ? GAP - 1 : 0);

    state_e           state_q, state_d, after_burst;
    logic [TILEW-1:0] num_q, tiles_q, tiles_d;
    logic [ADDRW-1:0] src_q, dst_q;
    logic [2:0]       row_q, gap_q;
    logic [1:0]       inflight_q, inflight_d;
    logic             done_q, done_d, accept, rd_vld_q, issue_last, retire;

    always_comb begin
        issue_last = (state_q == S_ISSUE) && (row_q == 3'(ROWS_PER_TILE - 1));
        tiles_d    = tiles_q + TILEW'(issue_last);
        inflight_d = inflight_q;
        if (issue_last && !retire)      inflight_d = inflight_q + 2'd1;
        else if (!issue_last && retire) inflight_d = inflight_q - 2'd1;

        // Decision after a burst looks at next-cycle counts so GAP=0 behaves like GAP>0.
        if (tiles_d == num_q)       after_burst = S_DRAIN;
        else if (inflight_d >= MAXI) after_burst = S_WAITC;
        else                         after_burst = S_ISSUE;

        state_d = state_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.num_tiles == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                        accept  = 1'b1;
                    end
                end
            end
            S_ISSUE: if (issue_last) state_d = (GAP == 0) ? after_burst : S_GAPW;
            S_GAPW:  if (gap_q == GAP_LAST) state_d = after_burst;
            S_WAITC: if (inflight_q < MAXI) state_d = S_ISSUE;
            S_DRAIN: begin
                if (inflight_q == 2'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            tiles_q    <= '0;
            row_q      <= '0;
            gap_q      <= '0;
            inflight_q <= '0;
            done_q     <= 1'b0;
            rd_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            rd_vld_q   <= (state_q == S_ISSUE);
            inflight_q <= inflight_d;
            gap_q      <= (state_q == S_GAPW) ? gap_q + 3'd1 : 3'd0;
            if (accept) begin
                num_q   <= bus.num_tiles;
                src_q   <= bus.src_base;
                dst_q   <= bus.dst_base;
                tiles_q <= '0;
                row_q   <= '0;
            end else begin
                tiles_q <= tiles_d;
                if (state_q == S_ISSUE) row_q <= row_q + 3'd1;
            end
        end
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_q;
    assign bus.rd_en       = (state_q == S_ISSUE);
    assign bus.rd_addr     = bus.rd_en ? src_q + ADDRW'({tiles_q, 3'b000}) + ADDRW'(row_q) : '0;
    assign bus.fft_invalid = rd_vld_q;

    // Read data lands one cycle after rd_en; imaginary halves are zero.
    always_comb begin
        bus.fft_indata = '0;
        if (rd_vld_q) begin
            for (int k = 0; k < FFTCHNL; k++)
                bus.fft_indata[k*CMPLXLEN +: CMPLXLEN] = {DATALEN'(0), bus.rd_data[k*DATALEN +: DATALEN]};
        end
    end

    fft2d_out_collector #(.ADDRW(ADDRW)) u_coll (
        .clk           (clk),
        .rst           (rst),
        .clr           (accept),
        .num_tiles     (num_q),
        .dst_base      (dst_q),
        .inflight_zero (inflight_q == 2'd0),
        .outvalid      (bus.fft_outvalid),
        .outdata       (bus.fft_outdata),
        .wr_en         (bus.wr_en),
        .wr_addr       (bus.wr_addr),
        .wr_data       (bus.wr_data),
        .retire        (retire),
        .err           (bus.err)
    );
endmodule

// File: tb/tb_fft2d_tile_sched.sv
// Bench for fft2d_tile_sched: row-buffer and fft2D models plus a write scoreboard,
// a table of jobs, and hand sequences for zero-length, stray-beat and mid-job reset.
module tb_fft2d_tile_sched;
    import fft_pkg::*;
    localparam int AW   = 12;
    localparam int MAXI = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft2d_tile_sched_if #(.ADDRW(AW)) bus();
    fft2d_tile_sched #(.ADDRW(AW), .MAX_INFLIGHT(MAXI), .GAP(1)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        int           n;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        int           lat;
        bit           mid;
    } job_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW-1:0]   rdq[$];
    logic [AW-1:0]   sb_addr[$];
    logic [OUTW-1:0] sb_data[$];
    int              readyq[$];
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0, done_cyc = -1, busy_seen = 0;
    int inflight_tb = 0, inflight_max = 0, row_in = 0, first_rd_cyc = -1;
    int tile2_first_rd = -1, tile0_last_beat = -1;
    int m_lat = 3, m_tile = 0, m_beat = 0;
    bit m_active = 0, stray_req = 0, flush = 0, last_rd_en = 0;
    logic [AW-1:0] m_dst = '0, last_rd_addr = '0;

    task automatic chk(input string name, input logic [OUTW-1:0] act, input logic [OUTW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [INW-1:0] mem_row(input logic [AW-1:0] a);
        logic [INW-1:0] r;
        for (int k = 0; k < FFTCHNL; k++) r[k*DATALEN +: DATALEN] = {a, 4'(k)};
        return r;
    endfunction

    function automatic logic [FFTINW-1:0] exp_in(input logic [AW-1:0] a);
        logic [FFTINW-1:0] r;
        logic [INW-1:0]    m;
        m = mem_row(a);
        for (int k = 0; k < FFTCHNL; k++) r[k*CMPLXLEN +: CMPLXLEN] = {16'h0000, m[k*DATALEN +: DATALEN]};
        return r;
    endfunction

    function automatic logic [OUTW-1:0] beat_data(input int t, input int b);
        logic [OUTW-1:0] d;
        for (int i = 0; i < OUTW / 32; i++) d[i*32 +: 32] = {16'(t) ^ 16'(i), 16'(b) + 16'h5a00};
        return d;
    endfunction

    // Models and monitors, all sampled on the falling edge.
    always @(negedge clk) begin
        if (flush) begin
            rdq.delete(); sb_addr.delete(); sb_data.delete(); readyq.delete();
            row_in = 0; m_active = 0; m_beat = 0; m_tile = 0; last_rd_en = 0;
            stray_req = 0; inflight_tb = 0; flush = 0;
            bus.fft_outvalid = 1'b0;
            bus.fft_outdata  = '0;
        end else begin
            if (bus.wr_en) begin
                wr_cnt++;
                if (sb_addr.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wr_unexpected: got wr_addr %0h want no write", bus.wr_addr);
                end else begin
                    chk("wr_addr", bus.wr_addr, sb_addr.pop_front());
                    chk("wr_data", bus.wr_data, sb_data.pop_front());
                end
                if (wr_cnt % 4 == 0) inflight_tb--;
            end
            if (bus.fft_invalid || last_rd_en) begin
                chk("fft_invalid", bus.fft_invalid, last_rd_en);
                if (last_rd_en) chk("fft_indata", bus.fft_indata, exp_in(last_rd_addr));
                if (bus.fft_invalid) begin
                    row_in++;
                    if (row_in == 8) begin
                        row_in = 0;
                        readyq.push_back(cyc + m_lat);
                    end
                end
            end
            last_rd_en   = bus.rd_en;
            last_rd_addr = bus.rd_addr;
            if (bus.rd_en) begin
                if (rd_cnt == 0)  first_rd_cyc = cyc;
                if (rd_cnt == 16) tile2_first_rd = cyc;
                rd_cnt++;
                if (rdq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL rd_unexpected: got rd_addr %0h want no read", bus.rd_addr);
                end else begin
                    chk("rd_addr", bus.rd_addr, rdq.pop_front());
                end
                bus.rd_data = mem_row(bus.rd_addr);
                if (rd_cnt % 8 == 0) begin
                    inflight_tb++;
                    if (inflight_tb > inflight_max) inflight_max = inflight_tb;
                end
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_at_done", bus.busy, 0);
            end
            if (bus.busy) busy_seen = 1;

            bus.fft_outvalid = 1'b0;
            if (stray_req) begin
                bus.fft_outvalid = 1'b1;
                bus.fft_outdata  = {16{32'hdeadbeef}};
                stray_req = 0;
            end else begin
                if (!m_active && readyq.size() > 0 && readyq[0] <= cyc) begin
                    void'(readyq.pop_front());
                    m_active = 1;
                    m_beat   = 0;
                end
                if (m_active) begin
                    bus.fft_outvalid = 1'b1;
                    bus.fft_outdata  = beat_data(m_tile, m_beat);
                    sb_addr.push_back(m_dst + AW'(4 * m_tile + m_beat));
                    sb_data.push_back(beat_data(m_tile, m_beat));
                    if (m_tile == 0 && m_beat == 3) tile0_last_beat = cyc;
                    m_beat++;
                    if (m_beat == 4) begin
                        m_active = 0;
                        m_tile++;
                    end
                end
            end
        end
    end

    task automatic clear_counts();
        rd_cnt = 0; wr_cnt = 0; done_cnt = 0; done_cyc = -1; busy_seen = 0;
        inflight_tb = 0; inflight_max = 0; first_rd_cyc = -1;
        tile2_first_rd = -1; tile0_last_beat = -1; m_tile = 0;
    endtask

    task automatic kick(input job_t j, output int t0);
        for (int t = 0; t < j.n; t++)
            for (int r = 0; r < 8; r++) rdq.push_back(j.src + AW'(8 * t + r));
        m_lat = j.lat;
        m_dst = j.dst;
        bus.start     = 1'b1;
        bus.num_tiles = 16'(j.n);
        bus.src_base  = j.src;
        bus.dst_base  = j.dst;
        t0 = cyc;
        @(negedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic run_job(input job_t j);
        int t0;
        int budget;
        @(negedge clk); #1;
        clear_counts();
        kick(j, t0);
        if (j.mid) begin
            repeat (4) @(negedge clk);
            #1;
            bus.start = 1'b1; bus.num_tiles = 16'd7; bus.src_base = 12'h700; bus.dst_base = 12'h7f0;
            @(negedge clk); #1;
            bus.start = 1'b0;
        end
        budget = 0;
        while (done_cnt == 0 && budget < 3000) begin
            @(negedge clk); #1;
            budget++;
        end
        if (done_cnt == 0) begin
            total++; bad++;
            $display("FAIL job_timeout: got no done want done within 3000 cycles");
        end
        repeat (3) @(negedge clk);
        #1;
        chk("first_rd_latency", first_rd_cyc - t0, 1);
        chk("rd_count", rd_cnt, 8 * j.n);
        chk("wr_count", wr_cnt, 4 * j.n);
        chk("done_count", done_cnt, 1);
        chk("busy_idle", bus.busy, 0);
        chk("rdq_drained", rdq.size(), 0);
        chk("sb_drained", sb_addr.size(), 0);
        chk("inflight_bound", inflight_max <= MAXI, 1);
    endtask

    job_t jobs[4];

    initial begin
        int t0;
        int budget;
        job_t j;
        bus.start = 1'b0; bus.num_tiles = '0; bus.src_base = '0; bus.dst_base = '0;

        jobs[0] = '{n: 1, src: 12'h010, dst: 12'h040, lat: 3,  mid: 0};
        jobs[1] = '{n: 5, src: 12'h100, dst: 12'h200, lat: 40, mid: 0};
        jobs[2] = '{n: 3, src: 12'hff0, dst: 12'hffc, lat: 2,  mid: 0};
        jobs[3] = '{n: 2, src: 12'h020, dst: 12'h080, lat: 5,  mid: 1};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_rd_addr", bus.rd_addr, 0);
        chk("rst_fft_invalid", bus.fft_invalid, 0);
        chk("rst_fft_indata", bus.fft_indata, 0);
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            run_job(jobs[i]);
            if (i == 1) chk("waitc_stall", tile2_first_rd > tile0_last_beat, 1);
        end

        // Zero-length job: done the next cycle, no traffic, never busy.
        @(negedge clk); #1;
        clear_counts();
        j = '{n: 0, src: 12'h123, dst: 12'h456, lat: 3, mid: 0};
        kick(j, t0);
        repeat (4) @(negedge clk);
        #1;
        chk("zero_done_lat", done_cyc - t0, 1);
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_busy", busy_seen, 0);
        chk("zero_rd", rd_cnt, 0);
        chk("zero_wr", wr_cnt, 0);

        // Stray output beat while idle: sticky err, nothing written, next job still fine.
        clear_counts();
        stray_req = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("stray_err", bus.err, 1);
        chk("stray_no_wr", wr_cnt, 0);
        run_job('{n: 1, src: 12'h050, dst: 12'h0a0, lat: 4, mid: 0});
        chk("err_sticky", bus.err, 1);

        // Reset during row 4 of the first tile, then restart from row 0.
        @(negedge clk); #1;
        clear_counts();
        j = '{n: 2, src: 12'h300, dst: 12'h010, lat: 3, mid: 0};
        kick(j, t0);
        budget = 0;
        while (rd_cnt < 5 && budget < 50) begin
            @(negedge clk); #1;
            budget++;
        end
        chk("mid_rst_row4_reached", rd_cnt, 5);
        rst   = 1'b1;
        flush = 1;
        @(negedge clk); #1;
        chk("mid_rst_rd_en", bus.rd_en, 0);
        chk("mid_rst_rd_addr", bus.rd_addr, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_fft_invalid", bus.fft_invalid, 0);
        chk("mid_rst_wr_en", bus.wr_en, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_err", bus.err, 0);
        rst = 1'b0;
        run_job('{n: 1, src: 12'h300, dst: 12'h060, lat: 3, mid: 0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish before 2ms");
        $fatal(1, "watchdog");
    end
endmodule
